// File: rtl/parking_time_tracker.sv
`default_nettype none
// ============================================================================
// Module      : parking_time_tracker
// Description : Multi-slot parking duration tracker. Keeps a free-running
//               time base, stores an entry timestamp per slot and, on exit,
//               registers elapsed time = now - entry (mod 2^TIME_W) with a
//               one-cycle valid strobe. Illegal events pulse err.
//               Optional macro PARKING_SAT_EN adds a per-slot wrapped flag
//               so that stays of 2^TIME_W ticks or more report 2^TIME_W-1.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_time_tracker #(
  parameter int TIME_W = 8,
  parameter int SLOTS  = 4,
  parameter int SLOT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              car_in,
  input  logic [SLOT_W-1:0] slot_in,
  input  logic              car_out,
  input  logic [SLOT_W-1:0] slot_out,
  output logic [TIME_W-1:0] now,
  output logic [TIME_W-1:0] duration,
  output logic              duration_valid,
  output logic              err,
  output logic [SLOTS-1:0]  occupied,
  output logic [SLOT_W:0]   free_count
);

  localparam logic [SLOT_W:0] c_slots = (SLOT_W + 1)'(SLOTS);

  logic [TIME_W-1:0] r_now;
  logic [TIME_W-1:0] r_dur;
  logic [TIME_W-1:0] r_stamp [SLOTS];
  logic              r_dv;
  logic              r_err;
  logic [SLOTS-1:0]  r_occ;
  logic [SLOT_W:0]   r_free;

  logic [SLOTS-1:0]  w_in_hit;
  logic [SLOTS-1:0]  w_out_hit;
  logic [SLOTS-1:0]  w_in_set;
  logic [SLOTS-1:0]  w_out_clr;
  logic [SLOTS-1:0]  w_occ_next;
  logic [SLOT_W:0]   w_pop;
  logic              w_in_range;
  logic              w_in_occ;
  logic              w_out_occ;
  logic              w_same_slot;
  logic              w_exit_ok;
  logic              w_in_ok;
  logic              w_err;
  logic [TIME_W-1:0] w_now_inc;
  logic [TIME_W-1:0] w_out_stamp;
  logic [TIME_W-1:0] w_dur_mod;
  logic [TIME_W-1:0] w_dur;

  // One-hot slot decode; an index beyond SLOTS decodes to all zeros.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign w_in_hit[gi]  = (slot_in  == SLOT_W'(gi));
      assign w_out_hit[gi] = (slot_out == SLOT_W'(gi));
    end
  endgenerate

  assign w_in_range  = |w_in_hit;
  assign w_in_occ    = |(w_in_hit & r_occ);
  assign w_out_occ   = |(w_out_hit & r_occ);
  assign w_same_slot = (slot_in == slot_out);
  assign w_now_inc   = r_now + TIME_W'(1);

  // An entry onto a slot that is being vacated in the same cycle is a re-stamp.
  assign w_exit_ok  = car_out & w_out_occ;
  assign w_in_ok    = car_in & w_in_range & (~w_in_occ | (w_exit_ok & w_same_slot));
  assign w_err      = (car_out & ~w_exit_ok) | (car_in & ~w_in_ok);
  assign w_out_clr  = w_exit_ok ? w_out_hit : '0;
  assign w_in_set   = w_in_ok ? w_in_hit : '0;
  assign w_occ_next = (r_occ & ~w_out_clr) | w_in_set;

  // Select the exiting slot's timestamp and count next-cycle occupancy.
  always_comb begin
    w_out_stamp = '0;
    w_pop       = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (w_out_hit[i]) w_out_stamp = r_stamp[i];
      w_pop = w_pop + (SLOT_W + 1)'(w_occ_next[i]);
    end
  end

  assign w_dur_mod = r_now - w_out_stamp;

`ifdef PARKING_SAT_EN
  logic [SLOTS-1:0] r_wrapped;
  logic             w_out_wrapped;

  // Flag a slot once the time base comes back round to its entry stamp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrapped <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (w_in_set[i] || w_out_clr[i]) begin
          r_wrapped[i] <= 1'b0;
        end else if (tick && r_occ[i] && (w_now_inc == r_stamp[i])) begin
          r_wrapped[i] <= 1'b1;
        end
      end
    end
  end

  assign w_out_wrapped = |(w_out_hit & r_wrapped);
  assign w_dur         = w_out_wrapped ? '1 : w_dur_mod;
`else
  assign w_dur = w_dur_mod;
`endif

  // Time base, exit result, error strobe and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_now  <= '0;
      r_dur  <= '0;
      r_dv   <= 1'b0;
      r_err  <= 1'b0;
      r_occ  <= '0;
      r_free <= c_slots;
    end else begin
      if (tick) r_now <= w_now_inc;
      if (w_exit_ok) r_dur <= w_dur;
      r_dv   <= w_exit_ok;
      r_err  <= w_err;
      r_occ  <= w_occ_next;
      r_free <= c_slots - w_pop;
    end
  end

  // Entry timestamps capture the pre-increment time base.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) r_stamp[i] <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (w_in_set[i]) r_stamp[i] <= r_now;
      end
    end
  end

  assign now            = r_now;
  assign duration       = r_dur;
  assign duration_valid = r_dv;
  assign err            = r_err;
  assign occupied       = r_occ;
  assign free_count     = r_free;

endmodule
`default_nettype wire

// File: tb/tb_parking_time_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_time_tracker
// Description : Self-checking bench for parking_time_tracker. Directed steps
//               followed by random events, checked against a model that
//               tracks absolute (unwrapped) time per slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_time_tracker;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       car_in;
  logic [1:0] slot_in;
  logic       car_out;
  logic [1:0] slot_out;
  logic [7:0] now;
  logic [7:0] duration;
  logic       duration_valid;
  logic       err;
  logic [3:0] occupied;
  logic [2:0] free_count;

  int checks = 0;
  int errors = 0;

  // Reference state: absolute tick count and absolute entry times.
  int m_abs;
  bit m_occ [4];
  int m_entry [4];
  int m_dur;
  bit m_dv;
  bit m_err;

  parking_time_tracker #(.TIME_W(8), .SLOTS(4), .SLOT_W(2)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .car_in(car_in), .slot_in(slot_in),
    .car_out(car_out), .slot_out(slot_out),
    .now(now), .duration(duration), .duration_valid(duration_valid),
    .err(err), .occupied(occupied), .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_abs = 0;
    m_dur = 0;
    m_dv  = 0;
    m_err = 0;
    for (int i = 0; i < 4; i++) begin
      m_occ[i]   = 0;
      m_entry[i] = 0;
    end
  endtask

  function automatic int model_occ_vec();
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_occ[i]) v |= (1 << i);
    return v;
  endfunction

  function automatic int model_free();
    int n = 4;
    for (int i = 0; i < 4; i++) if (m_occ[i]) n--;
    return n;
  endfunction

  task automatic compare_all();
    chk("now", now, m_abs % 256);
    chk("duration", duration, m_dur);
    chk("duration_valid", duration_valid, m_dv);
    chk("err", err, m_err);
    chk("occupied", occupied, model_occ_vec());
    chk("free_count", free_count, model_free());
  endtask

  // One clock: exit resolves first, then entry sees the freed slot, then tick.
  task automatic cycle(input bit t, input bit ci, input int si, input bit co, input int so);
    int el;
    tick = t; car_in = ci; slot_in = 2'(si); car_out = co; slot_out = 2'(so);
    @(posedge clk);
    #1;
    m_dv  = 0;
    m_err = 0;
    if (co) begin
      if (m_occ[so]) begin
        el = m_abs - m_entry[so];
`ifdef PARKING_SAT_EN
        m_dur = (el >= 256) ? 255 : el % 256;
`else
        m_dur = el % 256;
`endif
        m_dv = 1;
        m_occ[so] = 0;
      end else begin
        m_err = 1;
      end
    end
    if (ci) begin
      if (!m_occ[si]) begin
        m_occ[si]   = 1;
        m_entry[si] = m_abs;
      end else begin
        m_err = 1;
      end
    end
    if (t) m_abs++;
    tick = 0; car_in = 0; car_out = 0;
    compare_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) cycle(1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #7;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    tick = 0; car_in = 0; slot_in = 0; car_out = 0; slot_out = 0;
    reset = 1'b1;
    model_reset();
    #12;
    chk("reset_now", now, 0);
    chk("reset_free", free_count, 4);
    chk("reset_occ", occupied, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic stay of 20 ticks on slot 1.
    ticks(5);
    cycle(0, 1, 1, 0, 0);
    ticks(20);
    cycle(0, 0, 0, 1, 1);
    chk("basic_dur", duration, 20);
    chk("basic_dv", duration_valid, 1);
    chk("basic_free", free_count, 4);
    cycle(0, 0, 0, 0, 0);
    chk("basic_dv_drop", duration_valid, 0);

    // Stay that crosses the time-base wrap.
    ticks(225);
    chk("now_250", now, 250);
    cycle(0, 1, 0, 0, 0);
    ticks(10);
    chk("now_4", now, 4);
    cycle(0, 0, 0, 1, 0);
    chk("wrap_dur", duration, 10);

    // Double entry and exit from a free slot.
    cycle(0, 1, 2, 0, 0);
    cycle(0, 1, 2, 0, 0);
    chk("dbl_entry_err", err, 1);
    cycle(0, 0, 0, 1, 3);
    chk("free_exit_err", err, 1);
    chk("free_exit_dv", duration_valid, 0);
    chk("occ_0100", occupied, 4);

    // Same-slot exit and re-entry.
    ticks(3);
    cycle(0, 1, 3, 0, 0);
    ticks(5);
    cycle(0, 1, 3, 1, 3);
    chk("restamp_dur", duration, 5);
    chk("restamp_occ3", occupied[3], 1);
    ticks(3);
    cycle(0, 0, 0, 1, 3);
    chk("restamp_dur2", duration, 3);

    // Entry with tick in the same cycle, exit on another slot.
    cycle(1, 1, 3, 1, 2);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 2, 0, 0);
    chk("full_free", free_count, 0);

    // Asynchronous reset in the middle of activity.
    tick = 0; car_in = 0; car_out = 1; slot_out = 0;
    @(posedge clk);
    #2;
    car_out = 0;
    reset = 1'b1;
    #1;
    chk("arst_now", now, 0);
    chk("arst_occ", occupied, 0);
    chk("arst_free", free_count, 4);
    chk("arst_dv", duration_valid, 0);
    chk("arst_dur", duration, 0);
    chk("arst_err", err, 0);
    #4;
    reset = 1'b0;
    model_reset();
    @(negedge clk);

    // Stay longer than the time-base period.
    ticks(100);
    cycle(0, 1, 0, 0, 0);
    ticks(300);
    cycle(0, 0, 0, 1, 0);
`ifdef PARKING_SAT_EN
    chk("long_stay_dur", duration, 255);
`else
    chk("long_stay_dur", duration, 44);
`endif

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      cycle(bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 99) < 35), int'($urandom_range(0, 3)),
            bit'($urandom_range(0, 99) < 30), int'($urandom_range(0, 3)));
    end

    // Occasional long runs of ticks so stays cross the wrap.
    for (int k = 0; k < 20; k++) begin
      cycle(1, 1, int'($urandom_range(0, 3)), 0, 0);
      ticks(int'($urandom_range(200, 320)));
      cycle(0, 0, 0, 1, int'($urandom_range(0, 3)));
    end

    do_reset();
    chk("final_free", free_count, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
